// File: rtl/seq_rob_if.sv
// rtl/seq_rob_if.sv - dispatch/complete/commit bundle for the sequence reorder buffer
interface seq_rob_if #(
  parameter int p_seq_num_bits = 5
);
  logic                      alloc_val;
  logic                      alloc_rdy;
  logic [p_seq_num_bits-1:0] alloc_seq_num;

  logic                      cmpl_val;
  logic [p_seq_num_bits-1:0] cmpl_seq_num;
  logic [31:0]               cmpl_pc;
  logic [4:0]                cmpl_waddr;
  logic [31:0]               cmpl_wdata;
  logic                      cmpl_wen;

  logic                      commit_val;
  logic [p_seq_num_bits-1:0] commit_seq_num;
  logic [31:0]               commit_pc;
  logic [4:0]                commit_waddr;
  logic [31:0]               commit_wdata;
  logic                      commit_wen;

  logic [p_seq_num_bits:0]   occupancy;

  modport master (
    output alloc_val, cmpl_val, cmpl_seq_num, cmpl_pc, cmpl_waddr, cmpl_wdata, cmpl_wen,
    input  alloc_rdy, alloc_seq_num, commit_val, commit_seq_num, commit_pc,
           commit_waddr, commit_wdata, commit_wen, occupancy
  );

  modport slave (
    input  alloc_val, cmpl_val, cmpl_seq_num, cmpl_pc, cmpl_waddr, cmpl_wdata, cmpl_wen,
    output alloc_rdy, alloc_seq_num, commit_val, commit_seq_num, commit_pc,
           commit_waddr, commit_wdata, commit_wen, occupancy
  );
endinterface

// File: rtl/seq_rob.sv
// rtl/seq_rob.sv - in-order commit reorder buffer indexed by sequence number
module seq_rob #(
  parameter int p_seq_num_bits = 5
) (
  input logic     clk,
  input logic     rst,
  seq_rob_if.slave rob
);
  localparam int DEPTH = 1 << p_seq_num_bits;
  localparam logic [p_seq_num_bits:0] FULL = DEPTH[p_seq_num_bits:0];

  logic [p_seq_num_bits-1:0] head;
  logic [p_seq_num_bits-1:0] tail;
  logic [p_seq_num_bits:0]   count;
  logic [DEPTH-1:0]          alloc_q;
  logic [DEPTH-1:0]          done_q;
  logic [31:0]               pc_q    [DEPTH];
  logic [4:0]                waddr_q [DEPTH];
  logic [31:0]               wdata_q [DEPTH];
  logic [DEPTH-1:0]          wen_q;

  logic alloc_fire;
  logic cmpl_ok;
  logic commit_fire;

  // Ready comes from the registered count only, so a commit never frees a slot in the same cycle.
  assign rob.alloc_rdy     = (count < FULL);
  assign rob.alloc_seq_num = tail;
  assign rob.occupancy     = count;

  assign alloc_fire  = rob.alloc_val & rob.alloc_rdy;
  assign cmpl_ok     = rob.cmpl_val & alloc_q[rob.cmpl_seq_num] & ~done_q[rob.cmpl_seq_num];
  assign commit_fire = alloc_q[head] & done_q[head];

  assign rob.commit_val     = commit_fire;
  assign rob.commit_seq_num = head;
  assign rob.commit_pc      = pc_q[head];
  assign rob.commit_waddr   = waddr_q[head];
  assign rob.commit_wdata   = wdata_q[head];
  assign rob.commit_wen     = wen_q[head];

  // Index collisions are impossible: the head is already done (so cmpl_ok is 0 there),
  // and the tail is unallocated whenever an alloc can fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      if (commit_fire) begin
        alloc_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc_fire) begin
        alloc_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (cmpl_ok) begin
        done_q[rob.cmpl_seq_num] <= 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmpl_ok) begin
      pc_q[rob.cmpl_seq_num]    <= rob.cmpl_pc;
      waddr_q[rob.cmpl_seq_num] <= rob.cmpl_waddr;
      wdata_q[rob.cmpl_seq_num] <= rob.cmpl_wdata;
      wen_q[rob.cmpl_seq_num]   <= rob.cmpl_wen;
    end
  end
endmodule

// File: tb/tb_seq_rob.sv
// tb/tb_seq_rob.sv - directed scoreboard bench for seq_rob at 32 and 4 entries
module tb_seq_rob;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  seq_rob_if #(.p_seq_num_bits(5)) ia ();
  seq_rob_if #(.p_seq_num_bits(2)) ib ();

  seq_rob #(.p_seq_num_bits(5)) dut_a (.clk(clk), .rst(rst_a), .rob(ia.slave));
  seq_rob #(.p_seq_num_bits(2)) dut_b (.clk(clk), .rst(rst_b), .rob(ib.slave));

  typedef struct {
    logic [4:0]  seq;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic rec_t mk(input logic [4:0] s, input logic [31:0] d);
    rec_t r;
    r.seq   = s;
    r.pc    = 32'h0000_1000 + {25'd0, s, 2'b00};
    r.waddr = 5'(s + 5'd1);
    r.wdata = d;
    r.wen   = ~s[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmpl_a(input logic [4:0] s, input logic [31:0] d);
    rec_t r = mk(s, d);
    ia.cmpl_val     = 1'b1;
    ia.cmpl_seq_num = r.seq;
    ia.cmpl_pc      = r.pc;
    ia.cmpl_waddr   = r.waddr;
    ia.cmpl_wdata   = r.wdata;
    ia.cmpl_wen     = r.wen;
  endtask

  task automatic cmpl_b(input logic [4:0] s, input logic [31:0] d);
    rec_t r = mk(s, d);
    ib.cmpl_val     = 1'b1;
    ib.cmpl_seq_num = r.seq[1:0];
    ib.cmpl_pc      = r.pc;
    ib.cmpl_waddr   = r.waddr;
    ib.cmpl_wdata   = r.wdata;
    ib.cmpl_wen     = r.wen;
  endtask

  task automatic monitor();
    rec_t r;
    forever begin
      @(negedge clk);
      if (ia.commit_val === 1'b1) begin
        if (qa.size() == 0) chk("a_unexpected_commit", 64'd1, 64'd0);
        else begin
          r = qa.pop_front();
          chk("a_commit_seq",   64'(ia.commit_seq_num), 64'(r.seq));
          chk("a_commit_pc",    64'(ia.commit_pc),      64'(r.pc));
          chk("a_commit_waddr", 64'(ia.commit_waddr),   64'(r.waddr));
          chk("a_commit_wdata", 64'(ia.commit_wdata),   64'(r.wdata));
          chk("a_commit_wen",   64'(ia.commit_wen),     64'(r.wen));
        end
      end
      if (ib.commit_val === 1'b1) begin
        if (qb.size() == 0) chk("b_unexpected_commit", 64'd1, 64'd0);
        else begin
          r = qb.pop_front();
          chk("b_commit_seq",   64'(ib.commit_seq_num), 64'(r.seq[1:0]));
          chk("b_commit_pc",    64'(ib.commit_pc),      64'(r.pc));
          chk("b_commit_wdata", 64'(ib.commit_wdata),   64'(r.wdata));
          chk("b_commit_wen",   64'(ib.commit_wen),     64'(r.wen));
        end
      end
    end
  endtask

  task automatic stimulus();
    ia.alloc_val = 1'b0; ia.cmpl_val = 1'b0; ia.cmpl_seq_num = '0;
    ia.cmpl_pc = '0; ia.cmpl_waddr = '0; ia.cmpl_wdata = '0; ia.cmpl_wen = 1'b0;
    ib.alloc_val = 1'b0; ib.cmpl_val = 1'b0; ib.cmpl_seq_num = '0;
    ib.cmpl_pc = '0; ib.cmpl_waddr = '0; ib.cmpl_wdata = '0; ib.cmpl_wen = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;

    chk("a_reset_alloc_rdy",  64'(ia.alloc_rdy),     64'd1);
    chk("a_reset_alloc_seq",  64'(ia.alloc_seq_num), 64'd0);
    chk("a_reset_commit_val", 64'(ia.commit_val),    64'd0);
    chk("a_reset_occupancy",  64'(ia.occupancy),     64'd0);
    chk("b_reset_alloc_rdy",  64'(ib.alloc_rdy),     64'd1);
    chk("b_reset_occupancy",  64'(ib.occupancy),     64'd0);

    // Out-of-order completion, in-order commit
    for (int i = 0; i < 3; i++) begin
      ia.alloc_val = 1'b1;
      chk("a_alloc_seq", 64'(ia.alloc_seq_num), 64'(i));
      tick();
    end
    ia.alloc_val = 1'b0;
    chk("a_occ_after_3_alloc", 64'(ia.occupancy), 64'd3);
    cmpl_a(5'd2, 32'h2222_0002); tick();
    chk("a_no_commit_after_c2", 64'(ia.commit_val), 64'd0);
    cmpl_a(5'd1, 32'h1111_0001); tick();
    chk("a_no_commit_after_c1", 64'(ia.commit_val), 64'd0);
    cmpl_a(5'd0, 32'hC0DE_0000);
    qa.push_back(mk(5'd0, 32'hC0DE_0000));
    qa.push_back(mk(5'd1, 32'h1111_0001));
    qa.push_back(mk(5'd2, 32'h2222_0002));
    chk("a_no_same_cycle_bypass", 64'(ia.commit_val), 64'd0);
    tick();
    ia.cmpl_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("a_commit_burst", 64'(ia.commit_val), 64'd1);
      tick();
    end
    chk("a_burst_end",      64'(ia.commit_val), 64'd0);
    chk("a_burst_occ_zero", 64'(ia.occupancy),  64'd0);

    rst_a = 1'b1; tick(); rst_a = 1'b0;
    chk("a_rerst_alloc_seq", 64'(ia.alloc_seq_num), 64'd0);

    // Completion to a never-allocated seq is ignored
    ia.alloc_val = 1'b1; tick(); tick(); ia.alloc_val = 1'b0;
    cmpl_a(5'd5, 32'h5555_5555); tick();
    ia.cmpl_val = 1'b0;
    chk("a_stray_no_commit", 64'(ia.commit_val), 64'd0);
    chk("a_stray_occ",       64'(ia.occupancy),  64'd2);

    // Duplicate completion keeps the first payload
    cmpl_a(5'd1, 32'hAAAA_0001); tick();
    cmpl_a(5'd1, 32'hBBBB_0002); tick();
    chk("a_dup_no_commit", 64'(ia.commit_val), 64'd0);
    cmpl_a(5'd0, 32'h0000_0F00);
    qa.push_back(mk(5'd0, 32'h0000_0F00));
    qa.push_back(mk(5'd1, 32'hAAAA_0001));
    tick();
    ia.cmpl_val = 1'b0;
    chk("a_dup_commit0", 64'(ia.commit_val), 64'd1);
    tick();
    chk("a_dup_commit1", 64'(ia.commit_val), 64'd1);
    tick();
    chk("a_dup_end_occ", 64'(ia.occupancy), 64'd0);

    // Reset with done-but-blocked entries in flight
    ia.alloc_val = 1'b1; tick(); tick(); tick(); tick(); ia.alloc_val = 1'b0;
    cmpl_a(5'd3, 32'h3333_0003); tick();
    cmpl_a(5'd4, 32'h4444_0004); tick();
    cmpl_a(5'd5, 32'h5555_0005); tick();
    ia.cmpl_val = 1'b0;
    chk("a_blocked_occ",       64'(ia.occupancy),  64'd4);
    chk("a_blocked_no_commit", 64'(ia.commit_val), 64'd0);
    rst_a = 1'b1; tick();
    chk("a_midrst_commit",    64'(ia.commit_val),    64'd0);
    chk("a_midrst_occ",       64'(ia.occupancy),     64'd0);
    chk("a_midrst_alloc_seq", 64'(ia.alloc_seq_num), 64'd0);
    chk("a_midrst_alloc_rdy", 64'(ia.alloc_rdy),     64'd1);
    rst_a = 1'b0;
    cmpl_a(5'd3, 32'h3333_0003); tick();
    ia.cmpl_val = 1'b0;
    chk("a_postrst_no_commit", 64'(ia.commit_val), 64'd0);

    // Small buffer: full, commit with alloc pending, wrap
    for (int i = 0; i < 4; i++) begin
      ib.alloc_val = 1'b1;
      chk("b_alloc_seq", 64'(ib.alloc_seq_num), 64'(i));
      chk("b_alloc_rdy", 64'(ib.alloc_rdy),     64'd1);
      tick();
    end
    chk("b_full_rdy", 64'(ib.alloc_rdy), 64'd0);
    chk("b_full_occ", 64'(ib.occupancy), 64'd4);
    cmpl_b(5'd0, 32'h0000_00B0);
    qb.push_back(mk(5'd0, 32'h0000_00B0));
    tick();
    ib.cmpl_val = 1'b0;
    chk("b_full_commit_val", 64'(ib.commit_val), 64'd1);
    chk("b_full_commit_rdy", 64'(ib.alloc_rdy),  64'd0);
    tick();
    chk("b_after_commit_occ", 64'(ib.occupancy),     64'd3);
    chk("b_after_commit_rdy", 64'(ib.alloc_rdy),     64'd1);
    chk("b_wrap_alloc_seq",   64'(ib.alloc_seq_num), 64'd0);
    chk("b_after_commit_cv",  64'(ib.commit_val),    64'd0);
    tick();
    ib.alloc_val = 1'b0;
    chk("b_refill_occ", 64'(ib.occupancy),     64'd4);
    chk("b_refill_seq", 64'(ib.alloc_seq_num), 64'd1);

    cmpl_b(5'd0, 32'h0000_00B1); tick();
    cmpl_b(5'd3, 32'h0000_00B3); tick();
    cmpl_b(5'd2, 32'h0000_00B2); tick();
    chk("b_drain_wait", 64'(ib.commit_val), 64'd0);
    cmpl_b(5'd1, 32'h0000_00B4);
    qb.push_back(mk(5'd1, 32'h0000_00B4));
    qb.push_back(mk(5'd2, 32'h0000_00B2));
    qb.push_back(mk(5'd3, 32'h0000_00B3));
    qb.push_back(mk(5'd0, 32'h0000_00B1));
    tick();
    ib.cmpl_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b_drain_commit", 64'(ib.commit_val), 64'd1);
      tick();
    end
    chk("b_drain_end",     64'(ib.commit_val), 64'd0);
    chk("b_drain_end_occ", 64'(ib.occupancy),  64'd0);

    tick();
    chk("a_scoreboard_drained", 64'(qa.size()), 64'd0);
    chk("b_scoreboard_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
  end
endmodule
